alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Multi-cycle sequential execution stage sitting directly downstream of the bitwise half-add/half-sub primitives (XOR partial sum, AND carry vector).
- Accepts one ALU operation per valid/ready handshake and iterates partial-sum/carry pairs until the carry vector is zero, producing a full add, subtract or unsigned compare.
- Performs rotates serially, one bit per cycle.
- Result is returned through a valid/ready output handshake to the writeback stage.

Parameters:
- WIDTH, 32, operand and result width (power of two, >=4)
- SH_W, $clog2(WIDTH), rotate-amount width taken from b[SH_W-1:0]

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept (high only in IDLE)
- op  in  3  0 ADD, 1 SUB, 2 CMP, 3 ROR, 4 ROL, 5-7 illegal
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / rotate amount
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- carry  out  1  carry-out of MSB (ADD/SUB/CMP), 0 for rotates
- zero  out  1  result==0 (CMP: difference==0)
- op_err  out  1  illegal opcode flag, valid with out_valid

Behaviour:
- Reset: state=IDLE; in_ready=1 after reset deasserts; out_valid=0, result=0, carry=0, zero=0, op_err=0; internal s, c, cin_pend, cnt cleared.
- Reset mid-operation aborts immediately; the in-flight op is lost and no output is produced.
- FSM states: IDLE, ITER, DONE.
- IDLE: on in_valid&&in_ready, latch op/a/b and go to ITER. Initialisation per op:
  - ADD: s=a, c=b, cin_pend=0.
  - SUB/CMP: s=a, c=~b, cin_pend=1.
  - ROR/ROL: s=a, cnt=b[SH_W-1:0].
  - Illegal op: go straight to DONE with result=0, op_err=1.
- ITER, ADD/SUB/CMP, evaluated each cycle:
  - If c==0 && !cin_pend: go to DONE.
  - Else: s<=s^c; c<=((s&c)<<1)|cin_pend; cin_pend<=0; cout_acc|=(s&c)[WIDTH-1].
- ITER, ROR/ROL:
  - If cnt==0: go to DONE.
  - Else: s rotated by 1 in the op's direction; cnt<=cnt-1.
- Entering DONE registers the outputs:
  - ADD/SUB: result=s.
  - CMP: result={0..,~cout_acc} (unsigned a<b); zero=(s==0).
  - Other ops: zero=(result==0).
  - carry=cout_acc for ADD/SUB/CMP.
- DONE: out_valid=1. Outputs are held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid the next cycle.
- Latency: accept edge, then N ITER cycles, then out_valid. N = carry iterations + 1 (ADD/SUB/CMP, max WIDTH+2) or rotate amount + 1.
- No overlap: in_ready=0 in ITER and DONE. in_valid during busy is ignored and must be held by the producer.
- Rotate amount wraps modulo WIDTH (b=32 behaves as b=0 for WIDTH=32).
- Overflow of ADD is not flagged; only carry is reported.

Optional Feature:
- Macro: ALU_ITER_COUNT_EN.
- Defined: adds output iter_count, width $clog2(WIDTH+3). It counts ITER cycles of the current op, is registered with the result, holds in DONE, resets to 0, and is 0 for illegal ops.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ADD a=5, b=3, out_ready=1 -> result=8, carry=0, zero=0; out_valid 6 cycles after accept edge; iter_count=5.
- ADD a=0xFFFFFFFF, b=1 -> result=0, carry=1, zero=1. ADD a=7, b=0 -> result=7 after 1 ITER cycle.
- SUB a=3, b=5 -> result=0xFFFFFFFE, carry=0. CMP a=3, b=5 -> result=1, zero=0. CMP a=7, b=7 -> result=0, zero=1, carry=1.
- ROR a=0x80000001, b=4 -> 0x18000000 after 5 ITER cycles. ROL a=0x80000001, b=1 -> 0x00000003. ROL b=32 -> result=a, 1 ITER cycle.
- op=6 -> op_err=1, result=0. Then hold out_ready=0 for 3 cycles -> out_valid and result stable, in_ready=0; release -> in_ready=1 next cycle.
- Assert rst during ITER of ADD 5+3 -> next cycle out_valid=0, in_ready=1, no result ever emitted; a following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_iter_exec_if.sv
// Handshake bundle between issue, alu_iter_exec and writeback.
// Optional iter_count signal present when ALU_ITER_COUNT_EN is defined.
interface alu_iter_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             op_err;
`ifdef ALU_ITER_COUNT_EN
    logic [$clog2(WIDTH+3)-1:0] iter_count;
`endif

    modport master (
`ifdef ALU_ITER_COUNT_EN
        input  iter_count,
`endif
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, op_err
    );

    modport slave (
`ifdef ALU_ITER_COUNT_EN
        output iter_count,
`endif
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, op_err
    );
endinterface

// File: rtl/alu_iter_exec.sv
// Iterative ALU stage: add/sub/cmp via XOR/AND carry loop, serial rotates.
// Define ALU_ITER_COUNT_EN to expose the per-op ITER cycle count.
module alu_iter_exec #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    alu_iter_exec_if.slave io
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam int IC_W = $clog2(WIDTH+3);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             cin_pend_q, cin_pend_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic             cout_acc_q, cout_acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             op_err_q, op_err_d;
    logic [IC_W-1:0]  iter_cnt_q, iter_cnt_d;
    logic [WIDTH-1:0] sc;
    logic             is_arith;

`ifdef ALU_ITER_COUNT_EN
    logic [IC_W-1:0]  iter_count_q, iter_count_d;
`endif

    assign sc       = s_q & c_q;
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB)
                   || (op_q == OP_CMP);

    // Next-state, datapath iteration and output capture on DONE entry
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        s_d        = s_q;
        c_d        = c_q;
        cin_pend_d = cin_pend_q;
        cnt_d      = cnt_q;
        cout_acc_d = cout_acc_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        op_err_d   = op_err_q;
        iter_cnt_d = iter_cnt_q;
`ifdef ALU_ITER_COUNT_EN
        iter_count_d = iter_count_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    op_d       = io.op;
                    s_d        = io.a;
                    cout_acc_d = 1'b0;
                    iter_cnt_d = '0;
                    op_err_d   = 1'b0;
                    unique case (io.op)
                        OP_ADD: begin
                            c_d        = io.b;
                            cin_pend_d = 1'b0;
                            state_d    = ITER;
                        end
                        OP_SUB, OP_CMP: begin
                            c_d        = ~io.b;
                            cin_pend_d = 1'b1;
                            state_d    = ITER;
                        end
                        OP_ROR, OP_ROL: begin
                            cnt_d   = io.b[SH_W-1:0];
                            state_d = ITER;
                        end
                        default: begin
                            result_d = '0;
                            carry_d  = 1'b0;
                            zero_d   = 1'b1;
                            op_err_d = 1'b1;
`ifdef ALU_ITER_COUNT_EN
                            iter_count_d = '0;
`endif
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            ITER: begin
                iter_cnt_d = iter_cnt_q + 1'b1;
                if (is_arith) begin
                    if (c_q == '0 && !cin_pend_q) begin
                        state_d  = DONE;
                        carry_d  = cout_acc_q;
                        zero_d   = (s_q == '0);
                        result_d = (op_q == OP_CMP)
                                 ? {{(WIDTH-1){1'b0}}, ~cout_acc_q}
                                 : s_q;
`ifdef ALU_ITER_COUNT_EN
                        iter_count_d = iter_cnt_q + 1'b1;
`endif
                    end else begin
                        s_d        = s_q ^ c_q;
                        c_d        = (sc << 1)
                                   | {{(WIDTH-1){1'b0}}, cin_pend_q};
                        cin_pend_d = 1'b0;
                        cout_acc_d = cout_acc_q | sc[WIDTH-1];
                    end
                end else begin
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        result_d = s_q;
                        carry_d  = 1'b0;
                        zero_d   = (s_q == '0);
`ifdef ALU_ITER_COUNT_EN
                        iter_count_d = iter_cnt_q + 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (op_q == OP_ROR)
                            s_d = {s_q[0], s_q[WIDTH-1:1]};
                        else
                            s_d = {s_q[WIDTH-2:0], s_q[WIDTH-1]};
                    end
                end
            end
            DONE: begin
                if (io.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            s_q        <= '0;
            c_q        <= '0;
            cin_pend_q <= 1'b0;
            cnt_q      <= '0;
            cout_acc_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            op_err_q   <= 1'b0;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            s_q        <= s_d;
            c_q        <= c_d;
            cin_pend_q <= cin_pend_d;
            cnt_q      <= cnt_d;
            cout_acc_q <= cout_acc_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            op_err_q   <= op_err_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

`ifdef ALU_ITER_COUNT_EN
    // Reported count, captured together with the result
    always_ff @(posedge clk) begin
        if (rst)
            iter_count_q <= '0;
        else
            iter_count_q <= iter_count_d;
    end

    assign io.iter_count = iter_count_q;
`endif

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.result    = result_q;
    assign io.carry     = carry_q;
    assign io.zero      = zero_q;
    assign io.op_err    = op_err_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec.
// Builds with or without ALU_ITER_COUNT_EN.
module tb_alu_iter_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    int   seen;

    alu_iter_exec_if #(.WIDTH(32)) bus ();

    alu_iter_exec #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, output int l);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.op       = o;
        bus.a        = aa;
        bus.b        = bb;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        l = 1;
        while (!bus.out_valid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: out_valid never rose for op %0d", o);
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", {29'd0, bus.carry, bus.zero, bus.op_err}, 32'd0);
        rst = 1'b0;

        do_op(3'd0, 32'd5, 32'd3, lat);
        check("add_res", bus.result, 32'd8);
        check("add_flags", {29'd0, bus.carry, bus.zero, bus.op_err}, 32'd0);
        check("add_lat", lat, 32'd6);
        check("add_busy", {31'd0, bus.in_ready}, 32'd0);
`ifdef ALU_ITER_COUNT_EN
        check("add_iters", {26'd0, bus.iter_count}, 32'd5);
`endif
        consume();
        check("add_drop", {31'd0, bus.out_valid}, 32'd0);

        do_op(3'd0, 32'hFFFF_FFFF, 32'd1, lat);
        check("addc_res", bus.result, 32'd0);
        check("addc_cz", {30'd0, bus.carry, bus.zero}, 32'd3);
        consume();

        do_op(3'd0, 32'd7, 32'd0, lat);
        check("add0_res", bus.result, 32'd7);
        check("add0_lat", lat, 32'd2);
        consume();

        do_op(3'd1, 32'd3, 32'd5, lat);
        check("sub_res", bus.result, 32'hFFFF_FFFE);
        check("sub_carry", {31'd0, bus.carry}, 32'd0);
        consume();

        do_op(3'd2, 32'd3, 32'd5, lat);
        check("cmplt_res", bus.result, 32'd1);
        check("cmplt_zero", {31'd0, bus.zero}, 32'd0);
        consume();

        do_op(3'd2, 32'd7, 32'd7, lat);
        check("cmpeq_res", bus.result, 32'd0);
        check("cmpeq_cz", {30'd0, bus.carry, bus.zero}, 32'd3);
        consume();

        do_op(3'd3, 32'h8000_0001, 32'd4, lat);
        check("ror_res", bus.result, 32'h1800_0000);
        check("ror_lat", lat, 32'd6);
        check("ror_carry", {31'd0, bus.carry}, 32'd0);
        consume();

        do_op(3'd4, 32'h8000_0001, 32'd1, lat);
        check("rol_res", bus.result, 32'h0000_0003);
        consume();

        do_op(3'd4, 32'h1234_5678, 32'd32, lat);
        check("rol32_res", bus.result, 32'h1234_5678);
        check("rol32_lat", lat, 32'd2);
        consume();

        bus.out_ready = 1'b0;
        do_op(3'd6, 32'hDEAD_BEEF, 32'd9, lat);
        check("ill_err", {31'd0, bus.op_err}, 32'd1);
        check("ill_res", bus.result, 32'd0);
`ifdef ALU_ITER_COUNT_EN
        check("ill_iters", {26'd0, bus.iter_count}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_res", bus.result, 32'd0);
            check("hold_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        consume();
        check("rel_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rel_valid", {31'd0, bus.out_valid}, 32'd0);

        @(negedge clk);
        bus.op       = 3'd0;
        bus.a        = 32'd5;
        bus.b        = 32'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid)
                seen++;
        end
        check("abort_noout", seen, 32'd0);

        do_op(3'd0, 32'd1, 32'd1, lat);
        check("post_add", bus.result, 32'd2);
        consume();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
